// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer.
package counter_seq_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/counter_sequencer.sv
// Counter sequencer: drives an external up/down counter through a single
// up-ramp or a continuous triangle, and cross-checks the counter's value
// against an internal expected count one cycle after each command.
module counter_sequencer
    import counter_seq_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             mode_in,
    input  logic             abort_in,
    input  logic [CNT_W-1:0] start_val_in,
    input  logic [CNT_W-1:0] limit_in,
    input  logic [CNT_W-1:0] count_in,
    output logic             en_ctrl_out,
    output logic             set_ctrl_out,
    output logic             up_ctrl_out,
    output logic [CNT_W-1:0] counter_val_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [CNT_W-1:0] cycles_out,
    output logic             err_out
);

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] floor_q,  floor_d;
    logic [CNT_W-1:0] ceil_q,   ceil_d;
    logic             mode_q,   mode_d;
    logic [CNT_W-1:0] exp_q,    exp_d;
    logic             chk_q,    chk_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             err_q,    err_d;

    logic             en_q, set_q, up_q, busy_q, done_q;
    logic [CNT_W-1:0] val_q;

    assign en_ctrl_out     = en_q;
    assign set_ctrl_out    = set_q;
    assign up_ctrl_out     = up_q;
    assign counter_val_out = val_q;
    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign cycles_out      = cycles_q;
    assign err_out         = err_q;

    // Next-state, expected-count, period-count and error-flag computation.
    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        ceil_d   = ceil_q;
        mode_d   = mode_q;
        exp_d    = exp_q;
        cycles_d = cycles_q;
        err_d    = err_q;
        // The counter registers a command at the edge, so the value it
        // reports one cycle later must match the expected count then.
        chk_d    = en_q;

        if (chk_q && (count_in != exp_q)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    if (start_val_in < limit_in) begin
                        state_d  = ST_LOAD;
                        floor_d  = start_val_in;
                        ceil_d   = limit_in;
                        mode_d   = mode_in;
                        err_d    = 1'b0;
                        cycles_d = {CNT_W{1'b0}};
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                exp_d = floor_q;
                if (abort_in) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_UP;
                end
            end
            ST_UP: begin
                exp_d = exp_q + 8'd1;
                if (abort_in) begin
                    state_d = ST_DONE;
                end else if (exp_q == (ceil_q - 8'd1)) begin
                    state_d = mode_q ? ST_DOWN : ST_DONE;
                end else begin
                    state_d = ST_UP;
                end
            end
            ST_DOWN: begin
                exp_d = exp_q - 8'd1;
                if (exp_q == (floor_q + 8'd1)) begin
                    if (cycles_q != 8'd255) begin
                        cycles_d = cycles_q + 8'd1;
                    end else begin
                        cycles_d = cycles_q;
                    end
                end else begin
                    cycles_d = cycles_q;
                end
                if (abort_in) begin
                    state_d = ST_DONE;
                end else if (exp_q == (floor_q + 8'd1)) begin
                    state_d = ST_UP;
                end else begin
                    state_d = ST_DOWN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State/data registers; control outputs are decoded from the next state
    // so that they are registered yet always match the current state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            floor_q  <= {CNT_W{1'b0}};
            ceil_q   <= {CNT_W{1'b0}};
            mode_q   <= 1'b0;
            exp_q    <= {CNT_W{1'b0}};
            chk_q    <= 1'b0;
            cycles_q <= {CNT_W{1'b0}};
            err_q    <= 1'b0;
            en_q     <= 1'b0;
            set_q    <= 1'b0;
            up_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            val_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            ceil_q   <= ceil_d;
            mode_q   <= mode_d;
            exp_q    <= exp_d;
            chk_q    <= chk_d;
            cycles_q <= cycles_d;
            err_q    <= err_d;
            en_q     <= (state_d == ST_LOAD) || (state_d == ST_UP) || (state_d == ST_DOWN);
            busy_q   <= (state_d == ST_LOAD) || (state_d == ST_UP) || (state_d == ST_DOWN);
            set_q    <= (state_d == ST_LOAD);
            up_q     <= (state_d == ST_UP);
            done_q   <= (state_d == ST_DONE);
            val_q    <= (state_d == ST_LOAD) ? floor_d : {CNT_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural up/down counter
// as the plant and a per-cycle scoreboard of expected outputs.
module tb_counter_sequencer;

    logic       clk_s = 1'b0;
    logic       rst_s, start_s, mode_s, abort_s, fault_s;
    logic [7:0] start_val_s, limit_s, count_s, plant_q;
    logic       en_s, set_s, up_s, busy_s, done_s, err_s;
    logic [7:0] val_s, cycles_s;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cur_floor = 0;

    logic [29:0] exp_queue[$];
    string       tag_queue[$];

    counter_sequencer dut (
        .clk_in          (clk_s),
        .rst_in          (rst_s),
        .start_in        (start_s),
        .mode_in         (mode_s),
        .abort_in        (abort_s),
        .start_val_in    (start_val_s),
        .limit_in        (limit_s),
        .count_in        (count_s),
        .en_ctrl_out     (en_s),
        .set_ctrl_out    (set_s),
        .up_ctrl_out     (up_s),
        .counter_val_out (val_s),
        .busy_out        (busy_s),
        .done_out        (done_s),
        .cycles_out      (cycles_s),
        .err_out         (err_s)
    );

    always #5 clk_s = ~clk_s;

    // Plant: 8-bit loadable up/down counter, optionally overridden by a fault.
    always @(posedge clk_s) begin
        if (rst_s)      plant_q <= 8'd0;
        else if (en_s) begin
            if (set_s)      plant_q <= val_s;
            else if (up_s)  plant_q <= plant_q + 8'd1;
            else            plant_q <= plant_q - 8'd1;
        end
    end
    assign count_s = fault_s ? 8'h00 : plant_q;

    // Push expected outputs for the next cycle, advance one clock, then pop
    // and compare. st: I=idle L=load U=up D=down N=done.
    task automatic cyc(input string tag, input byte st, input int cyc_n,
                       input bit err, input int cnt);
        logic [4:0]  ctl;
        logic [7:0]  val;
        logic [29:0] e, o;
        string       t;
        case (st)
            "L":     ctl = 5'b11010;
            "U":     ctl = 5'b10110;
            "D":     ctl = 5'b10010;
            "N":     ctl = 5'b00001;
            default: ctl = 5'b00000;
        endcase
        val = (st == "L") ? 8'(cur_floor) : 8'd0;
        exp_queue.push_back({ctl, err, 8'(cyc_n), val, 8'(cnt)});
        tag_queue.push_back(tag);
        @(posedge clk_s);
        #1;
        o = {en_s, set_s, up_s, busy_s, done_s, err_s, cycles_s, val_s, count_s};
        e = exp_queue.pop_front();
        t = tag_queue.pop_front();
        total_cnt++;
        assert (o === e) pass_cnt++;
        else $error("FAIL %s: observed en/set/up/busy/done/err/cyc/val/cnt=%h expected=%h", t, o, e);
    endtask

    initial begin
        rst_s = 1'b1; start_s = 1'b0; mode_s = 1'b0; abort_s = 1'b0; fault_s = 1'b0;
        start_val_s = 8'd0; limit_s = 8'd0;

        // Reset state
        cyc("reset0", "I", 0, 1'b0, 0);
        cyc("reset1", "I", 0, 1'b0, 0);
        rst_s = 1'b0;
        cyc("idle", "I", 0, 1'b0, 0);

        // Single up-ramp 3..6
        start_s = 1'b1; mode_s = 1'b0; start_val_s = 8'd3; limit_s = 8'd6; cur_floor = 3;
        cyc("ramp_load", "L", 0, 1'b0, 0);
        start_s = 1'b0;
        cyc("ramp_up3", "U", 0, 1'b0, 3);
        cyc("ramp_up4", "U", 0, 1'b0, 4);
        cyc("ramp_up5", "U", 0, 1'b0, 5);
        cyc("ramp_done", "N", 0, 1'b0, 6);
        cyc("ramp_idle", "I", 0, 1'b0, 6);

        // Triangle 3..6, two full periods, then abort
        start_s = 1'b1; mode_s = 1'b1;
        cyc("tri_load", "L", 0, 1'b0, 6);
        start_s = 1'b0;
        for (int p = 0; p < 2; p++) begin
            cyc("tri_up3", "U", p, 1'b0, 3);
            cyc("tri_up4", "U", p, 1'b0, 4);
            cyc("tri_up5", "U", p, 1'b0, 5);
            cyc("tri_dn6", "D", p, 1'b0, 6);
            cyc("tri_dn5", "D", p, 1'b0, 5);
            cyc("tri_dn4", "D", p, 1'b0, 4);
        end
        cyc("tri_up3_p2", "U", 2, 1'b0, 3);
        abort_s = 1'b1;
        cyc("tri_abort_done", "N", 2, 1'b0, 4);
        abort_s = 1'b0;
        cyc("tri_idle", "I", 2, 1'b0, 4);

        // Abort during UP at 4; start held high outside IDLE is ignored
        start_s = 1'b1; mode_s = 1'b0;
        cyc("ab_load", "L", 0, 1'b0, 4);
        cyc("ab_up3", "U", 0, 1'b0, 3);
        cyc("ab_up4", "U", 0, 1'b0, 4);
        start_s = 1'b0; abort_s = 1'b1;
        cyc("ab_done", "N", 0, 1'b0, 5);
        abort_s = 1'b0;
        cyc("ab_idle0", "I", 0, 1'b0, 5);
        cyc("ab_idle1", "I", 0, 1'b0, 5);

        // Illegal start (floor == ceiling), then a valid start clears err
        start_s = 1'b1; start_val_s = 8'd9; limit_s = 8'd9;
        cyc("illegal", "I", 0, 1'b1, 5);
        start_s = 1'b0;
        cyc("illegal_hold", "I", 0, 1'b1, 5);
        start_s = 1'b1; mode_s = 1'b1; start_val_s = 8'd3; limit_s = 8'd6; cur_floor = 3;
        cyc("clr_load", "L", 0, 1'b0, 5);
        start_s = 1'b0;
        cyc("clr_up3", "U", 0, 1'b0, 3);
        cyc("clr_up4", "U", 0, 1'b0, 4);
        cyc("clr_up5", "U", 0, 1'b0, 5);
        cyc("clr_dn6", "D", 0, 1'b0, 6);

        // Reset in the middle of DOWN
        rst_s = 1'b1;
        cyc("rst_mid_down", "I", 0, 1'b0, 0);
        rst_s = 1'b0;
        cyc("rst_after", "I", 0, 1'b0, 0);

        // Period counter saturation: floor 0, ceiling 1, triangle
        start_s = 1'b1; mode_s = 1'b1; start_val_s = 8'd0; limit_s = 8'd1; cur_floor = 0;
        cyc("sat_load", "L", 0, 1'b0, 0);
        start_s = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc("sat_up", "U", (i > 255) ? 255 : i, 1'b0, 0);
            cyc("sat_dn", "D", (i > 255) ? 255 : i, 1'b0, 1);
        end
        abort_s = 1'b1;
        cyc("sat_done", "N", 255, 1'b0, 0);
        abort_s = 1'b0;
        cyc("sat_idle", "I", 255, 1'b0, 0);

        // Fault injection: counter value forced to 0 for one cycle during UP
        start_s = 1'b1; mode_s = 1'b1; start_val_s = 8'd3; limit_s = 8'd6; cur_floor = 3;
        cyc("flt_load", "L", 0, 1'b0, 0);
        start_s = 1'b0;
        cyc("flt_up3", "U", 0, 1'b0, 3);
        fault_s = 1'b1;
        cyc("flt_forced", "U", 0, 1'b1, 0);
        fault_s = 1'b0;
        cyc("flt_up5", "U", 0, 1'b1, 5);
        cyc("flt_dn6", "D", 0, 1'b1, 6);
        cyc("flt_dn5", "D", 0, 1'b1, 5);
        cyc("flt_dn4", "D", 0, 1'b1, 4);
        cyc("flt_up3b", "U", 1, 1'b1, 3);
        abort_s = 1'b1;
        cyc("flt_done", "N", 1, 1'b1, 4);
        abort_s = 1'b0;
        cyc("flt_idle0", "I", 1, 1'b1, 4);
        cyc("flt_idle1", "I", 1, 1'b1, 4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have ports: clk_in  input  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_in  input  1  reset; synchronous, active-high.
REQ-003 SHALL have ports: start_in  input  1  start request, sampled in IDLE only.
REQ-004 SHALL have ports: mode_in  input  1  0 = single up-ramp, 1 = continuous triangle; latched at start.
REQ-005 SHALL have ports: abort_in  input  1  stop the active sequence.
REQ-006 SHALL have ports: start_val_in  input  8  ramp floor; latched at start.
REQ-007 SHALL have ports: limit_in  input  8  ramp ceiling; latched at start.
REQ-008 SHALL have ports: count_in  input  8  count value fed back from the driven up/down counter.
REQ-009 SHALL have ports: en_ctrl_out, set_ctrl_out, up_ctrl_out  output  1 each  counter control strobes.
REQ-010 SHALL have ports: counter_val_out  output  8  load value; equals latched floor in LOAD, else 0.
REQ-011 SHALL have ports: busy_out  output  1  high in LOAD, UP and DOWN.
REQ-012 SHALL have ports: done_out  output  1  one-cycle pulse in DONE.
REQ-013 SHALL have ports: cycles_out  output  8  completed triangle periods, saturating at 255.
REQ-014 SHALL have ports: err_out  output  1  sticky error flag.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, UP, DOWN and DONE; control outputs are Moore-decoded from state.
REQ-016 IDLE: all strobes 0; start_in=1 with start_val_in < limit_in -> LOAD, latch floor/ceiling/mode, clear err_out and cycles_out.
REQ-017 IDLE: start_in=1 with start_val_in >= limit_in -> stay IDLE and set err_out.
REQ-018 LOAD: en=1, set=1, up=0; exp_q <= floor; next UP.
REQ-019 UP: en=1, up=1, set=0; exp_q <= exp_q+1; when exp_q == ceiling-1 this is the last increment -> DOWN if mode=1, DONE if mode=0.
REQ-020 DOWN: en=1, up=0, set=0; exp_q <= exp_q-1; when exp_q == floor+1 this is the last decrement -> cycles_out += 1 (saturating at 255), next UP.
REQ-021 DONE: all strobes 0, done_out=1 for exactly one cycle; next IDLE.
REQ-022 abort_in=1 in LOAD/UP/DOWN: next state DONE; the current cycle's command is still issued and exp_q still updates; abort_in in IDLE/DONE is ignored.
REQ-023 start_in outside IDLE SHALL be ignored.
REQ-024 Feedback check: chk_q <= 1 on every cycle with en_ctrl_out=1; when chk_q=1 and count_in != exp_q, set err_out (1-cycle latency: counter registers the command, sequencer compares next cycle).
REQ-025 err_out SHALL remain set until reset or the next valid start.
REQ-026 Arithmetic SHALL be 8-bit unsigned; exp_q never wraps, because floor < ceiling is enforced.

Reset
REQ-027 rst_in=1 at a clock edge SHALL force IDLE from any state, including mid-ramp.
REQ-028 Reset values: all strobes 0, counter_val_out=0, busy_out=0, done_out=0, cycles_out=0, err_out=0, exp_q=0, chk_q=0.
REQ-029 rst_in SHALL take priority over start_in and abort_in.

Structure
REQ-030 Package counter_seq_pkg SHALL hold the state enum typedef and constant CNT_W=8.
REQ-031 The block SHALL be a single module with no sub-modules; the bench drives count_in from the existing 8-bit up/down counter as the plant.

Verification
REQ-032 Single ramp: start at cycle 0 with floor 3, ceiling 6, mode 0 -> LOAD at cycle 1, UP at cycles 2-4, done_out at cycle 5, count_in sequence 3,4,5,6, err_out=0.
REQ-033 Triangle: floor 3, ceiling 6, mode 1 -> count_in 3,4,5,6,5,4,3,4...; cycles_out increments 0->1->2 after each descent to 3.
REQ-034 Illegal start: start_val_in=9, limit_in=9 -> stays IDLE, busy_out=0, err_out=1; a following valid start clears err_out.
REQ-035 Abort: abort_in pulsed during UP at exp_q=4 -> one DONE pulse, then IDLE; no commands after DONE.
REQ-036 Fault injection: bench forces count_in to 0x00 for one cycle during UP -> err_out=1 on the following cycle and remains set to the end of the run.
REQ-037 Reset mid-DOWN, and cycles saturation: rst_in during DOWN -> IDLE next cycle with all outputs 0; floor 0, ceiling 1, mode 1 held for more than 512 cycles -> cycles_out holds at 255.
